// File: rtl/vdp_pkg.sv
// vdp_pkg: constants shared by the VRAM arbiter and its helpers.
//   - CPU port mode values (data vs. address/control)
//   - second-control-byte command encodings in din[7:6]
//   - cmd_decode(): maps din[7:6] onto a command enum
package vdp_pkg;

    localparam logic MODE_DATA = 1'b0;
    localparam logic MODE_CTRL = 1'b1;

    // Register write matches 2'b1x, so it is described as code + mask.
    localparam logic [1:0] CMD_REG_CODE = 2'b10;
    localparam logic [1:0] CMD_REG_MASK = 2'b10;
    localparam logic [1:0] CMD_WR_CODE  = 2'b01;
    localparam logic [1:0] CMD_RD_CODE  = 2'b00;

    typedef enum logic [1:0] {
        CMD_RD  = 2'b00,
        CMD_WR  = 2'b01,
        CMD_REG = 2'b10
    } cmd_e;

    function automatic cmd_e cmd_decode(input logic [1:0] bits);
        cmd_e c;
        if ((bits & CMD_REG_MASK) == CMD_REG_CODE) begin
            c = CMD_REG;
        end else if (bits == CMD_WR_CODE) begin
            c = CMD_WR;
        end else begin
            c = CMD_RD;
        end
        return c;
    endfunction

endpackage

// File: rtl/vram_mem.sv
// vram_mem: single-port synchronous byte RAM, one access per clock.
// Ports:
//   clk      - clock
//   reset    - async active-high; clears only the read register, never the array
//   i_re     - read enable; o_rdata loads mem[i_addr] at the edge
//   i_we     - write enable; mem[i_addr] <= i_wdata at the edge
//   i_addr   - access address
//   i_wdata  - write data
//   o_rdata  - registered read data, holds between reads
module vram_mem #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_re,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [7:0]            i_wdata,
    output logic [7:0]            o_rdata
);

    logic [7:0] r_mem [0:(2**ADDR_WIDTH)-1];

    // Array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Registered read port; only loads on a real read so the value is stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_rdata <= 8'h00;
        end else if (i_re) begin
            o_rdata <= r_mem[i_addr];
        end else begin
            o_rdata <= o_rdata;
        end
    end

endmodule

// File: rtl/vram_arb.sv
// vram_arb: VRAM arbiter between a byte-wide CPU port and a display fetch port.
// Ports:
//   clk, reset              - pixel clock; async active-high reset
//   wr_tick, rd_tick, mode  - CPU strobes; mode 0 = data, 1 = address/control
//   din / dout              - CPU write data / read buffer
//   busy, overrun           - CPU op in flight / sticky dropped-tick flag
//   reg_wr, reg_num, reg_data - one-cycle register-write command
//   vid_req, vid_addr       - display fetch request (strict priority)
//   vid_ack, vid_data       - fetch result, one edge after a granted request
module vram_arb
    import vdp_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int REG_AW     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_tick,
    input  logic                  rd_tick,
    input  logic                  mode,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    output logic                  busy,
    output logic                  overrun,
    output logic                  reg_wr,
    output logic [REG_AW-1:0]     reg_num,
    output logic [7:0]            reg_data,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_ack,
    output logic [7:0]            vid_data
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_pend_addr;
    logic [7:0]            r_lsb;
    logic [7:0]            r_pend_data;
    logic [7:0]            r_rbuf;
    logic                  r_phase;
    logic                  r_pend_valid;
    logic                  r_pend_we;
    logic                  r_rd_inflight;
    logic                  r_busy;
    logic                  r_overrun;
    logic                  r_reg_wr;
    logic [REG_AW-1:0]     r_reg_num;
    logic [7:0]            r_reg_data;
    logic                  r_vid_ack;

    logic                  w_tick;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_mem_go;
    cmd_e                  w_cmd;
    logic [ADDR_WIDTH-1:0] w_latch_addr;
    logic                  w_ram_re;
    logic                  w_ram_we;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [7:0]            w_ram_q;

    // Any tick while busy is dropped; when both strobes fire, wr_tick wins.
    assign w_tick       = wr_tick | rd_tick;
    assign w_accept     = w_tick & ~r_busy;
    assign w_drop       = w_tick & r_busy;
    assign w_mem_go     = r_pend_valid & ~vid_req;
    assign w_cmd        = cmd_decode(din[7:6]);
    assign w_latch_addr = ADDR_WIDTH'({din[5:0], r_lsb});

    // RAM port mux: display fetch always wins, else the pending CPU op.
    always_comb begin
        w_ram_re   = 1'b0;
        w_ram_we   = 1'b0;
        w_ram_addr = vid_addr;
        if (vid_req) begin
            w_ram_re   = 1'b1;
            w_ram_addr = vid_addr;
        end else if (r_pend_valid) begin
            w_ram_re   = ~r_pend_we;
            w_ram_we   = r_pend_we;
            w_ram_addr = r_pend_addr;
        end else begin
            w_ram_re   = 1'b0;
            w_ram_addr = vid_addr;
        end
    end

    vram_mem #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .i_re    (w_ram_re),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (r_pend_data),
        .o_rdata (w_ram_q)
    );

    // CPU command decode, pending slot, read buffer and video ack.
    // Accepts only happen with r_busy=0 while execute/return only happen with
    // r_busy=1, so the two groups never assign the same register in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr        <= {ADDR_WIDTH{1'b0}};
            r_pend_addr   <= {ADDR_WIDTH{1'b0}};
            r_lsb         <= 8'h00;
            r_pend_data   <= 8'h00;
            r_rbuf        <= 8'h00;
            r_phase       <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_pend_we     <= 1'b0;
            r_rd_inflight <= 1'b0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
            r_reg_wr      <= 1'b0;
            r_reg_num     <= {REG_AW{1'b0}};
            r_reg_data    <= 8'h00;
            r_vid_ack     <= 1'b0;
        end else begin
            r_reg_wr  <= 1'b0;
            r_vid_ack <= vid_req;
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
            // Pending op reaches the RAM on the first edge without vid_req.
            if (w_mem_go) begin
                r_pend_valid <= 1'b0;
                if (r_pend_we) begin
                    r_busy <= 1'b0;
                end else begin
                    r_rd_inflight <= 1'b1;
                end
            end
            // Read data is in the RAM output register one edge after the access.
            if (r_rd_inflight) begin
                r_rbuf        <= w_ram_q;
                r_rd_inflight <= 1'b0;
                r_busy        <= 1'b0;
            end
            if (w_accept) begin
                if (mode == MODE_DATA) begin
                    r_phase      <= 1'b0;
                    r_pend_valid <= 1'b1;
                    r_pend_addr  <= r_addr;
                    r_addr       <= r_addr + ADDR_ONE;
                    r_busy       <= 1'b1;
                    r_pend_we    <= wr_tick;
                    if (wr_tick) begin
                        r_pend_data <= din;
                        r_rbuf      <= din;
                    end
                end else if (!wr_tick) begin
                    r_phase <= 1'b0;
                end else if (!r_phase) begin
                    r_lsb   <= din;
                    r_phase <= 1'b1;
                end else begin
                    r_phase <= 1'b0;
                    case (w_cmd)
                        CMD_REG: begin
                            r_reg_wr   <= 1'b1;
                            r_reg_num  <= din[REG_AW-1:0];
                            r_reg_data <= r_lsb;
                        end
                        CMD_WR: begin
                            r_addr <= w_latch_addr;
                        end
                        CMD_RD: begin
                            r_pend_valid <= 1'b1;
                            r_pend_we    <= 1'b0;
                            r_pend_addr  <= w_latch_addr;
                            r_addr       <= w_latch_addr + ADDR_ONE;
                            r_busy       <= 1'b1;
                        end
                        default: begin
                            r_phase <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign dout     = r_rbuf;
    assign busy     = r_busy;
    assign overrun  = r_overrun;
    assign reg_wr   = r_reg_wr;
    assign reg_num  = r_reg_num;
    assign reg_data = r_reg_data;
    assign vid_ack  = r_vid_ack;
    assign vid_data = w_ram_q;

endmodule

// File: tb/tb_vram_arb.sv
// tb_vram_arb: directed-vector bench for vram_arb with a dout scoreboard.
module tb_vram_arb;

    logic        clk;
    logic        reset;
    logic        wr_tick;
    logic        rd_tick;
    logic        mode;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        busy;
    logic        overrun;
    logic        reg_wr;
    logic [2:0]  reg_num;
    logic [7:0]  reg_data;
    logic        vid_req;
    logic [13:0] vid_addr;
    logic        vid_ack;
    logic [7:0]  vid_data;

    vram_arb #(.ADDR_WIDTH(14), .REG_AW(3)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .wr_tick  (wr_tick),
        .rd_tick  (rd_tick),
        .mode     (mode),
        .din      (din),
        .dout     (dout),
        .busy     (busy),
        .overrun  (overrun),
        .reg_wr   (reg_wr),
        .reg_num  (reg_num),
        .reg_data (reg_data),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .vid_ack  (vid_ack),
        .vid_data (vid_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       chk;
        logic [7:0] val;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] m_mem [int];
    int         m_addr;
    int         n_checks;
    int         n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected rbuf after a prefetch of address a (unknown bytes are not checked).
    task automatic push_exp(input int a);
        exp_t e;
        if (m_mem.exists(a)) e = '{1'b1, m_mem[a]};
        else                 e = '{1'b0, 8'h00};
        sb_q.push_back(e);
    endtask

    // Drive a one-cycle tick; entered and left at posedge+1.
    task automatic tick(input logic wr, input logic rd, input logic md, input logic [7:0] d);
        wr_tick = wr;
        rd_tick = rd;
        mode    = md;
        din     = d;
        @(posedge clk); #1;
        wr_tick = 1'b0;
        rd_tick = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_idle busy still high after %0d cycles", k);
        end
    endtask

    task automatic cpu_addr(input logic [7:0] lo, input logic [7:0] hi);
        if (!hi[7]) begin
            m_addr = int'({hi[5:0], lo});
            if (!hi[6]) begin
                push_exp(m_addr);
                m_addr = (m_addr + 1) & 32'h3FFF;
            end
        end
        tick(1'b1, 1'b0, 1'b1, lo);
        tick(1'b1, 1'b0, 1'b1, hi);
        wait_idle();
    endtask

    task automatic cpu_write(input logic [7:0] d);
        sb_q.push_back('{1'b1, d});
        m_mem[m_addr] = d;
        m_addr = (m_addr + 1) & 32'h3FFF;
        tick(1'b1, 1'b0, 1'b0, d);
        wait_idle();
    endtask

    task automatic cpu_read();
        push_exp(m_addr);
        m_addr = (m_addr + 1) & 32'h3FFF;
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        wait_idle();
    endtask

    // Monitor: every busy fall presents a new dout; compare against the queue head.
    initial begin
        logic prev_busy;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !busy) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL sb_underflow dout=%0h with no expected entry", dout);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.chk) check("sb_dout", {24'h0, dout}, {24'h0, e.val});
                    end
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_addr   = 0;
        reset    = 1'b1;
        wr_tick  = 1'b0;
        rd_tick  = 1'b0;
        mode     = 1'b0;
        din      = 8'h00;
        vid_req  = 1'b0;
        vid_addr = 14'h0000;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_dout", dout, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_reg_wr", reg_wr, 1'b0);
        check("rst_reg_num", reg_num, 3'd0);
        check("rst_reg_data", reg_data, 8'h00);
        check("rst_vid_ack", vid_ack, 1'b0);
        check("rst_vid_data", vid_data, 8'h00);

        // Bulk: write setup 0x0200, 8192 writes, read setup 0x0200, 8192 reads
        cpu_addr(8'h00, 8'h42);
        for (int i = 0; i < 8192; i++) cpu_write(i[7:0]);
        cpu_addr(8'h00, 8'h02);
        for (int i = 0; i < 8192; i++) begin
            check("bulk_rd", dout, i[7:0]);
            cpu_read();
        end
        check("bulk_overrun", overrun, 1'b0);

        // Address wrap at 0x3FFF
        cpu_addr(8'hFF, 8'h7F);
        cpu_write(8'hAA);
        cpu_write(8'hBB);
        cpu_addr(8'hFF, 8'h3F);
        check("wrap_3fff", dout, 8'hAA);
        cpu_read();
        check("wrap_0000", dout, 8'hBB);

        // Register write leaves the address alone
        cpu_addr(8'h05, 8'h02);
        check("reg_pre", dout, 8'h05);
        tick(1'b1, 1'b0, 1'b1, 8'h5C);
        tick(1'b1, 1'b0, 1'b1, 8'h83);
        check("reg_wr_pulse", reg_wr, 1'b1);
        check("reg_num", reg_num, 3'd3);
        check("reg_data", reg_data, 8'h5C);
        check("reg_busy", busy, 1'b0);
        @(posedge clk); #1;
        check("reg_wr_end", reg_wr, 1'b0);
        cpu_read();
        check("reg_addr_kept", dout, 8'h06);

        // Video priority stalls a pending write for 10 cycles
        cpu_addr(8'h00, 8'h50);
        sb_q.push_back('{1'b1, 8'h77});
        m_mem[32'h1000] = 8'h77;
        m_addr   = 32'h1001;
        vid_req  = 1'b1;
        vid_addr = 14'h0200;
        wr_tick  = 1'b1;
        mode     = 1'b0;
        din      = 8'h77;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            wr_tick = 1'b0;
            check("vid_busy", busy, 1'b1);
            check("vid_ack", vid_ack, 1'b1);
            check("vid_data", vid_data, k);
            if (k < 9) vid_addr = 14'h0201 + 14'(k);
            else       vid_req  = 1'b0;
        end
        @(posedge clk); #1;
        check("vid_busy_fall", busy, 1'b0);
        check("vid_ack_fall", vid_ack, 1'b0);
        cpu_addr(8'h00, 8'h10);
        check("vid_write_landed", dout, 8'h77);

        // Overrun: second write tick while busy is dropped
        cpu_addr(8'h01, 8'h51);
        cpu_write(8'h5A);
        cpu_addr(8'h00, 8'h51);
        sb_q.push_back('{1'b1, 8'h31});
        m_mem[32'h1100] = 8'h31;
        m_addr  = 32'h1101;
        wr_tick = 1'b1;
        mode    = 1'b0;
        din     = 8'h31;
        @(posedge clk); #1;
        din = 8'h32;
        @(posedge clk); #1;
        wr_tick = 1'b0;
        check("ovr_flag", overrun, 1'b1);
        wait_idle();
        cpu_addr(8'h00, 8'h11);
        check("ovr_first", dout, 8'h31);
        cpu_read();
        check("ovr_second_absent", dout, 8'h5A);

        // Reset during a pending (video-stalled) write
        cpu_addr(8'h05, 8'h43);
        vid_req  = 1'b1;
        vid_addr = 14'h0000;
        tick(1'b1, 1'b0, 1'b0, 8'h99);
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_dout", dout, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_overrun", overrun, 1'b0);
        check("mid_rst_reg_wr", reg_wr, 1'b0);
        check("mid_rst_reg_num", reg_num, 3'd0);
        check("mid_rst_reg_data", reg_data, 8'h00);
        check("mid_rst_vid_ack", vid_ack, 1'b0);
        check("mid_rst_vid_data", vid_data, 8'h00);
        vid_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        cpu_addr(8'h05, 8'h03);
        check("rst_target_kept", dout, 8'h05);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
